// File: rtl/abp_pkg.sv
// Shared Alternating Bit Protocol definitions: packet layout and transmitter FSM states.
// Used by both the sender transmitter and the receiver.
package abp_pkg;

    localparam int ABP_PKT_BYTES = 9;
    localparam int ABP_CTRL_IDX  = 8;
    localparam int ABP_SEQ_POS   = 0;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT_ACK
    } abp_tx_state_t;

endpackage

// File: rtl/abp_timeout_timer.sv
// Up-counter for the ACK wait window.
// It expires on the cycle the count reaches TIMEOUT_CYCLES-1 while enabled.
module abp_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q, count_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TW'(1);
        end
    end

    // NOTE: state flops use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/abp_sender_transmitter.sv
// ABP sender: serialises a 64-bit value plus a sequence byte as a 9-byte AXI4-Stream packet.
// It then waits for the matching ACK, retransmitting on timeout up to MAX_RETRIES times.
module abp_sender_transmitter
    import abp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 15
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        send_valid,
    output logic        send_ready,
    input  logic [63:0] send_value,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    input  logic        ack_valid,
    input  logic        ack_bit,
    output logic        busy,
    output logic        seq_bit,
    output logic        send_done,
    output logic        send_abort
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
    localparam logic [3:0]    CTRL_IDX    = 4'(ABP_CTRL_IDX);

    abp_tx_state_t state_q, state_d;
    logic [63:0]   value_q, value_d;
    logic [3:0]    idx_q, idx_d;
    logic          seq_q, seq_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    logic          timer_expire;
    logic          ack_match;
    logic [7:0]    ctrl_byte;

    abp_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (state_q != TX_WAIT_ACK),
        .enable  (state_q == TX_WAIT_ACK),
        .expire  (timer_expire)
    );

    assign ack_match = ack_valid && (ack_bit == seq_q);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (send_valid) begin
                    value_d = send_value;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (m_axis_tready) begin
                    if (idx_q == CTRL_IDX) begin
                        state_d = TX_WAIT_ACK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            TX_WAIT_ACK: begin
                // A matching ACK takes priority over a simultaneous timeout.
                if (ack_match) begin
                    done_d  = 1'b1;
                    seq_d   = ~seq_q;
                    retry_d = '0;
                    state_d = TX_IDLE;
                end else if (timer_expire) begin
                    if ((MAX_RETRIES != 0) && (retry_q == RETRY_LIMIT)) begin
                        abort_d = 1'b1;
                        retry_d = '0;
                        state_d = TX_IDLE;
                    end else begin
                        if (retry_q != '1) begin
                            retry_d = retry_q + RW'(1);
                        end
                        idx_d   = '0;
                        state_d = TX_SEND;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= TX_IDLE;
            value_q <= '0;
            idx_q   <= '0;
            seq_q   <= 1'b0;
            retry_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        ctrl_byte              = '0;
        ctrl_byte[ABP_SEQ_POS] = seq_q;
        m_axis_tdata           = '0;
        if (state_q == TX_SEND) begin
            m_axis_tdata = (idx_q == CTRL_IDX) ? ctrl_byte
                                               : value_q[{idx_q[2:0], 3'b000} +: 8];
        end
    end

    // Gated by aresetn so the app sees no ready while the block is held in reset.
    assign send_ready    = aresetn && (state_q == TX_IDLE);
    assign m_axis_tvalid = (state_q == TX_SEND);
    assign m_axis_tlast  = (state_q == TX_SEND) && (idx_q == CTRL_IDX);
    assign busy          = (state_q != TX_IDLE);
    assign seq_bit       = seq_q;
    assign send_done     = done_q;
    assign send_abort    = abort_q;

endmodule

// File: tb/tb_abp_sender_transmitter.sv
// Directed self-checking bench for abp_sender_transmitter (TIMEOUT_CYCLES=16, MAX_RETRIES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_abp_sender_transmitter;

    localparam int TMO  = 16;
    localparam int MAXR = 2;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        send_valid;
    logic        send_ready;
    logic [63:0] send_value;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic        ack_valid;
    logic        ack_bit;
    logic        busy;
    logic        seq_bit;
    logic        send_done;
    logic        send_abort;

    int checks = 0;
    int errors = 0;

    abp_sender_transmitter #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .send_valid    (send_valid),
        .send_ready    (send_ready),
        .send_value    (send_value),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .ack_valid     (ack_valid),
        .ack_bit       (ack_bit),
        .busy          (busy),
        .seq_bit       (seq_bit),
        .send_done     (send_done),
        .send_abort    (send_abort)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":send_ready"}, send_ready,    1'b0);
        check({tag, ":tvalid"},     m_axis_tvalid, 1'b0);
        check({tag, ":tlast"},      m_axis_tlast,  1'b0);
        check({tag, ":tdata"},      m_axis_tdata,  8'h00);
        check({tag, ":busy"},       busy,          1'b0);
        check({tag, ":seq_bit"},    seq_bit,       1'b0);
        check({tag, ":send_done"},  send_done,     1'b0);
        check({tag, ":send_abort"}, send_abort,    1'b0);
    endtask

    task automatic send(input string tag, input logic [63:0] val);
        int n = 0;
        while (!send_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check({tag, ":ready_seen"}, send_ready, 1'b1);
        send_valid = 1'b1;
        send_value = val;
        @(negedge aclk);
        send_valid = 1'b0;
        check({tag, ":busy_after_accept"},  busy,       1'b1);
        check({tag, ":ready_after_accept"}, send_ready, 1'b0);
    endtask

    // Collects one 9-byte packet, checking each byte, tlast, and stability during stalls.
    task automatic get_packet(input string tag, input logic [63:0] val, input logic seq,
                              input bit rnd);
        int         got = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        logic [7:0] exp_b;
        while (got < 9 && cyc < 400) begin
            if (got > 0) check({tag, ":tvalid_held"}, m_axis_tvalid, 1'b1);
            if (stalled) begin
                check({tag, ":stall_tdata"}, m_axis_tdata, prev_data);
                check({tag, ":stall_tlast"}, m_axis_tlast, prev_last);
            end
            m_axis_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            stalled   = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                exp_b = (got == 8) ? {7'b0, seq} : val[got*8 +: 8];
                check($sformatf("%s:byte%0d", tag, got), m_axis_tdata, exp_b);
                check($sformatf("%s:tlast%0d", tag, got), m_axis_tlast, (got == 8));
                got++;
            end
            @(negedge aclk);
            cyc++;
        end
        check({tag, ":byte_count"}, got, 9);
        m_axis_tready = 1'b1;
        check({tag, ":tvalid_after_pkt"}, m_axis_tvalid, 1'b0);
    endtask

    // Cycles from the last byte transfer until tvalid rises again.
    task automatic check_retx_gap(input string tag);
        int n = 0;
        while (!m_axis_tvalid && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check({tag, ":retx_gap"}, n, TMO);
    endtask

    task automatic ack_done(input string tag, input logic b, input logic exp_seq);
        ack_valid = 1'b1;
        ack_bit   = b;
        @(negedge aclk);
        ack_valid = 1'b0;
        check({tag, ":send_done"},  send_done,  1'b1);
        check({tag, ":seq_toggle"}, seq_bit,    exp_seq);
        check({tag, ":busy_clear"}, busy,       1'b0);
        check({tag, ":ready_back"}, send_ready, 1'b1);
        @(negedge aclk);
        check({tag, ":done_pulse"}, send_done,  1'b0);
    endtask

    initial begin
        int n;
        logic [63:0] v;
        aresetn       = 1'b0;
        send_valid    = 1'b0;
        send_value    = '0;
        m_axis_tready = 1'b1;
        ack_valid     = 1'b0;
        ack_bit       = 1'b0;

        // 1: reset values, basic packet, matching ACK
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle:send_ready", send_ready, 1'b1);
        check("idle:busy", busy, 1'b0);
        v = 64'h0807060504030201;
        send("t1", v);
        get_packet("t1", v, 1'b0, 1'b0);
        repeat (2) @(negedge aclk);
        ack_done("t1", 1'b0, 1'b1);

        // 2: random backpressure
        v = 64'hDEADBEEFCAFEF00D;
        send("t2", v);
        get_packet("t2", v, 1'b1, 1'b1);
        ack_done("t2", 1'b1, 1'b0);

        // 3: timeout then retransmit, ACK on second try
        v = 64'h1122334455667788;
        send("t3", v);
        get_packet("t3", v, 1'b0, 1'b0);
        check_retx_gap("t3");
        check("t3:busy_retx", busy, 1'b1);
        get_packet("t3_retx", v, 1'b0, 1'b0);
        ack_done("t3", 1'b0, 1'b1);

        v = 64'hA5A5_5A5A_0F0F_F0F0;
        send("t3b", v);
        get_packet("t3b", v, 1'b1, 1'b0);
        ack_done("t3b", 1'b1, 1'b0);

        // 4: stale ACK ignored
        v = 64'h0123456789ABCDEF;
        send("t4", v);
        get_packet("t4", v, 1'b0, 1'b0);
        repeat (3) @(negedge aclk);
        ack_valid = 1'b1;
        ack_bit   = 1'b1;
        @(negedge aclk);
        ack_valid = 1'b0;
        check("t4:stale_done", send_done, 1'b0);
        check("t4:stale_busy", busy, 1'b1);
        check("t4:stale_seq", seq_bit, 1'b0);
        repeat (2) @(negedge aclk);
        check("t4:no_retx", m_axis_tvalid, 1'b0);
        ack_done("t4", 1'b0, 1'b1);

        // 5: no ACK at all -> 3 packets then abort
        v = 64'hFEDCBA9876543210;
        send("t5", v);
        for (int p = 0; p < 3; p++) begin
            get_packet($sformatf("t5_p%0d", p), v, 1'b1, 1'b0);
            if (p < 2) check_retx_gap($sformatf("t5_p%0d", p));
        end
        n = 0;
        while (!send_abort && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("t5:abort_delay", n, TMO);
        check("t5:abort", send_abort, 1'b1);
        check("t5:busy", busy, 1'b0);
        check("t5:seq_kept", seq_bit, 1'b1);
        check("t5:no_4th_pkt", m_axis_tvalid, 1'b0);
        check("t5:no_done", send_done, 1'b0);
        @(negedge aclk);
        check("t5:abort_pulse", send_abort, 1'b0);
        check("t5:ready", send_ready, 1'b1);

        // 6: reset in the middle of a packet
        v = 64'h8877665544332211;
        send("t6", v);
        m_axis_tready = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 4; c++) begin
            if (m_axis_tvalid) n++;
            @(negedge aclk);
        end
        check("t6:byte4_presented", m_axis_tdata, 8'h55);
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset_outputs("t6_reset");
        aresetn = 1'b1;
        @(negedge aclk);
        v = 64'h0F1E2D3C4B5A6978;
        send("t6_post", v);
        get_packet("t6_post", v, 1'b0, 1'b0);
        ack_done("t6_post", 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
